// File: rtl/uc_pkg.sv
// Shared encodings for the CPU control unit: opcodes, next-PC selects, FSM states
// and the decoded control word.
package uc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned S_INC_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD  = 6'b010000;
  localparam logic [OP_W-1:0] OP_STORE = 6'b010001;
  localparam logic [OP_W-1:0] OP_J     = 6'b100000;
  localparam logic [OP_W-1:0] OP_JZ    = 6'b100001;
  localparam logic [OP_W-1:0] OP_JNZ   = 6'b100010;
  localparam logic [OP_W-1:0] OP_CALL  = 6'b100011;
  localparam logic [OP_W-1:0] OP_RET   = 6'b100100;
  localparam logic [OP_W-1:0] OP_RETI  = 6'b100101;
  localparam logic [OP_W-1:0] OP_EI    = 6'b110000;
  localparam logic [OP_W-1:0] OP_DI    = 6'b110001;

  localparam logic [ALU_W-1:0] ALU_PASS_A = 3'b000;

  localparam logic [S_INC_W-1:0] S_INC_JMP = 2'b00;
  localparam logic [S_INC_W-1:0] S_INC_SEQ = 2'b01;
  localparam logic [S_INC_W-1:0] S_INC_VEC = 2'b10;

  typedef enum logic {RUN = 1'b0, ISR = 1'b1} state_e;

  typedef struct packed {
    logic               push;
    logic               pop;
    logic               s_intr;
    logic               s_stack_mux;
    logic [S_INC_W-1:0] s_inc;
    logic               s_mux_alu;
    logic               s_mux_datos;
    logic               transceiver_oe;
    logic               we3;
    logic               wez;
    logic [ALU_W-1:0]   op_alu;
  } ctl_t;

  // Instructions that touch the stack or ie must never be displaced by an interrupt entry.
  function automatic logic is_ctl_op(input logic [OP_W-1:0] op);
    return op inside {OP_CALL, OP_RET, OP_RETI, OP_EI, OP_DI};
  endfunction

endpackage

// File: rtl/uc_sequencer_if.sv
// Instruction/flag inputs and datapath control outputs of the control unit.
interface uc_sequencer_if
  import uc_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
);
  logic [OP_W-1:0]    opcode;
  logic               z;
  logic [N_IRQ-1:0]   intr;
  logic               push;
  logic               pop;
  logic               s_intr;
  logic               s_stack_mux;
  logic [S_INC_W-1:0] s_inc;
  logic               s_mux_alu;
  logic               s_mux_datos;
  logic               transceiver_oe;
  logic               we3;
  logic               wez;
  logic [ALU_W-1:0]   op_alu;
  logic [N_IRQ-1:0]   intr_sel;
  logic               ie;
  logic               in_service;
  logic               stk_err;

  modport master (
    output opcode, z, intr,
    input  push, pop, s_intr, s_stack_mux, s_inc, s_mux_alu, s_mux_datos,
           transceiver_oe, we3, wez, op_alu, intr_sel, ie, in_service, stk_err
  );

  modport slave (
    input  opcode, z, intr,
    output push, pop, s_intr, s_stack_mux, s_inc, s_mux_alu, s_mux_datos,
           transceiver_oe, we3, wez, op_alu, intr_sel, ie, in_service, stk_err
  );
endinterface

// File: rtl/irq_prio.sv
// Interrupt capture: per-line synchroniser, rising-edge detect, sticky pending
// register and fixed-priority (lowest index wins) one-hot select.
module irq_prio #(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] intr,
  input  logic             grant,
  output logic             pend_any,
  output logic [N_IRQ-1:0] sel
);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0]                  prev_q;
  logic [N_IRQ-1:0]                  pend_q;
  logic [N_IRQ-1:0]                  rise_c;

  assign rise_c   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign pend_any = |pend_q;
  // Isolate the lowest set bit.
  assign sel      = pend_q & (~pend_q + N_IRQ'(1));

  // A fresh edge on the granted line re-posts it, since the OR follows the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= intr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      pend_q <= (pend_q & ~(grant ? sel : '0)) | rise_c;
    end
  end

endmodule

// File: rtl/uc_sequencer.sv
// Control unit for the 16-bit single-cycle CPU: opcode decode, interrupt
// entry/return sequencing and return-stack depth guarding.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  uc_sequencer_if.slave  bus
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  state_e             state;
  logic               ie_q;
  logic               in_service_q;
  logic               stk_err_q;
  logic [DEPTH_W-1:0] depth;

  ctl_t               ctl_c;
  logic               grant_c;
  logic               pend_any_c;
  logic               err_c;
  logic [N_IRQ-1:0]   sel_c;
  logic [N_IRQ-1:0]   intr_sel_c;

  irq_prio #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_irq_prio (
    .clk      (clk),
    .reset    (reset),
    .intr     (bus.intr),
    .grant    (grant_c),
    .pend_any (pend_any_c),
    .sel      (sel_c)
  );

  // Decode; an interrupt grant replaces the current instruction, which is re-fetched on return.
  always_comb begin
    ctl_c       = '0;
    ctl_c.s_inc = S_INC_SEQ;
    intr_sel_c  = '0;
    grant_c     = 1'b0;
    err_c       = 1'b0;
    if (reset) begin
      grant_c = (state == RUN) && ie_q && pend_any_c &&
                (depth < DEPTH_W'(STACK_DEPTH)) && !is_ctl_op(bus.opcode);
      if (grant_c) begin
        ctl_c.push   = 1'b1;
        ctl_c.s_intr = 1'b1;
        ctl_c.s_inc  = S_INC_VEC;
        intr_sel_c   = sel_c;
      end else begin
        casez (bus.opcode)
          6'b000???: begin
            ctl_c.op_alu = bus.opcode[ALU_W-1:0];
            ctl_c.we3    = 1'b1;
            ctl_c.wez    = 1'b1;
          end
          6'b001???: begin
            ctl_c.op_alu    = bus.opcode[ALU_W-1:0];
            ctl_c.we3       = 1'b1;
            ctl_c.wez       = 1'b1;
            ctl_c.s_mux_alu = 1'b1;
          end
          OP_LOAD: begin
            ctl_c.s_mux_alu   = 1'b1;
            ctl_c.op_alu      = ALU_PASS_A;
            ctl_c.s_mux_datos = 1'b1;
            ctl_c.we3         = 1'b1;
          end
          OP_STORE: begin
            ctl_c.s_mux_alu      = 1'b1;
            ctl_c.op_alu         = ALU_PASS_A;
            ctl_c.transceiver_oe = 1'b1;
          end
          OP_J:   ctl_c.s_inc = S_INC_JMP;
          OP_JZ:  ctl_c.s_inc = bus.z ? S_INC_JMP : S_INC_SEQ;
          OP_JNZ: ctl_c.s_inc = bus.z ? S_INC_SEQ : S_INC_JMP;
          OP_CALL: begin
            ctl_c.s_inc = S_INC_JMP;
            if (depth == DEPTH_W'(STACK_DEPTH)) err_c = 1'b1;
            else                                ctl_c.push = 1'b1;
          end
          OP_RET, OP_RETI: begin
            if (depth == '0) begin
              err_c = 1'b1;
            end else begin
              ctl_c.pop         = 1'b1;
              ctl_c.s_stack_mux = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // FSM, interrupt enable/service flags and stack depth tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      ie_q         <= 1'b0;
      in_service_q <= 1'b0;
      stk_err_q    <= 1'b0;
      depth        <= '0;
    end else begin
      depth <= depth + DEPTH_W'(ctl_c.push) - DEPTH_W'(ctl_c.pop);
      if (err_c) stk_err_q <= 1'b1;
      if (grant_c) begin
        state        <= ISR;
        ie_q         <= 1'b0;
        in_service_q <= 1'b1;
      end else begin
        case (bus.opcode)
          OP_RETI: begin
            state        <= RUN;
            ie_q         <= 1'b1;
            in_service_q <= 1'b0;
          end
          OP_EI:   ie_q <= 1'b1;
          OP_DI:   ie_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.push           = ctl_c.push;
  assign bus.pop            = ctl_c.pop;
  assign bus.s_intr         = ctl_c.s_intr;
  assign bus.s_stack_mux    = ctl_c.s_stack_mux;
  assign bus.s_inc          = ctl_c.s_inc;
  assign bus.s_mux_alu      = ctl_c.s_mux_alu;
  assign bus.s_mux_datos    = ctl_c.s_mux_datos;
  assign bus.transceiver_oe = ctl_c.transceiver_oe;
  assign bus.we3            = ctl_c.we3;
  assign bus.wez            = ctl_c.wez;
  assign bus.op_alu         = ctl_c.op_alu;
  assign bus.intr_sel       = intr_sel_c;
  assign bus.ie             = ie_q;
  assign bus.in_service     = in_service_q;
  assign bus.stk_err        = stk_err_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Randomised and directed bench for uc_sequencer against a cycle-level behavioural model.
module tb_uc_sequencer;
  import uc_pkg::*;

  localparam int unsigned NI = 8;
  localparam int unsigned SD = 16;
  localparam int unsigned SS = 2;
  localparam logic [5:0]  NOP = 6'b111111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uc_sequencer_if #(.N_IRQ(NI)) bus ();

  uc_sequencer #(.N_IRQ(NI), .STACK_DEPTH(SD), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bit          m_ie, m_insvc, m_isr, m_err;
  int          m_depth;
  bit [NI-1:0] m_pend;
  bit [NI-1:0] m_hist[$];   // intr as sampled at recent edges, [0] newest

  bit [21:0]   e_ctl;
  bit          e_grant;
  bit [NI-1:0] e_sel;

  // Last observed outputs, for directed checks
  logic        l_push, l_pop, l_sintr, l_smux, l_malu, l_mdat, l_oe, l_we3, l_wez;
  logic [1:0]  l_sinc;
  logic [2:0]  l_opalu;
  logic [NI-1:0] l_sel;

  function automatic bit [21:0] pack_ctl(bit push, bit pop, bit sintr, bit smux, bit [1:0] sinc,
                                         bit malu, bit mdat, bit oe, bit we3, bit wez,
                                         bit [2:0] opalu, bit [NI-1:0] sel);
    return {push, pop, sintr, smux, sinc, malu, mdat, oe, we3, wez, opalu, sel};
  endfunction

  task automatic model_reset();
    m_ie = 0; m_insvc = 0; m_isr = 0; m_err = 0; m_depth = 0; m_pend = '0;
    m_hist.delete();
    repeat (SS + 1) m_hist.push_back('0);
  endtask

  task automatic model_out(input bit [5:0] op, input bit zz);
    bit push = 0, pop = 0, sintr = 0, smux = 0, malu = 0, mdat = 0, oe = 0, we3 = 0, wez = 0;
    bit [1:0] sinc = 2'd1;
    bit [2:0] opalu = 0;
    bit ctl_op;
    int lo = -1;
    ctl_op = (op == OP_CALL) || (op == OP_RET) || (op == OP_RETI) || (op == OP_EI) || (op == OP_DI);
    for (int i = 0; i < NI; i++) if (m_pend[i] && lo < 0) lo = i;
    e_sel   = '0;
    e_grant = !m_isr && m_ie && (lo >= 0) && (m_depth < SD) && !ctl_op;
    if (e_grant) begin
      push = 1; sintr = 1; sinc = 2'd2;
      e_sel[lo] = 1'b1;
    end else if (op < 16) begin
      opalu = 3'(op % 8); we3 = 1; wez = 1; malu = (op >= 8);
    end else if (op == OP_LOAD) begin
      malu = 1; mdat = 1; we3 = 1;
    end else if (op == OP_STORE) begin
      malu = 1; oe = 1;
    end else if (op == OP_J) begin
      sinc = 0;
    end else if (op == OP_JZ) begin
      sinc = zz ? 2'd0 : 2'd1;
    end else if (op == OP_JNZ) begin
      sinc = zz ? 2'd1 : 2'd0;
    end else if (op == OP_CALL) begin
      sinc = 0; push = (m_depth < SD);
    end else if (op == OP_RET || op == OP_RETI) begin
      pop = (m_depth > 0); smux = pop;
    end
    e_ctl = pack_ctl(push, pop, sintr, smux, sinc, malu, mdat, oe, we3, wez, opalu, e_sel);
  endtask

  task automatic model_step(input bit [5:0] op, input bit [NI-1:0] ir);
    bit [NI-1:0] rise;
    rise = m_hist[SS-1] & ~m_hist[SS];
    if (e_grant) begin
      m_pend &= ~e_sel; m_ie = 0; m_insvc = 1; m_isr = 1; m_depth++;
    end else if (op == OP_CALL) begin
      if (m_depth == SD) m_err = 1; else m_depth++;
    end else if (op == OP_RET || op == OP_RETI) begin
      if (m_depth == 0) m_err = 1; else m_depth--;
      if (op == OP_RETI) begin m_ie = 1; m_insvc = 0; m_isr = 0; end
    end else if (op == OP_EI) m_ie = 1;
    else if (op == OP_DI) m_ie = 0;
    m_pend |= rise;
    m_hist.push_front(ir);
    void'(m_hist.pop_back());
  endtask

  // One instruction cycle; entered and left just after a rising edge.
  task automatic cycle(input bit [5:0] op, input bit zz, input bit [NI-1:0] ir);
    bit [21:0] act;
    bus.opcode = op; bus.z = zz; bus.intr = ir;
    #1;
    model_out(op, zz);
    l_push = bus.push; l_pop = bus.pop; l_sintr = bus.s_intr; l_smux = bus.s_stack_mux;
    l_sinc = bus.s_inc; l_malu = bus.s_mux_alu; l_mdat = bus.s_mux_datos; l_oe = bus.transceiver_oe;
    l_we3 = bus.we3; l_wez = bus.wez; l_opalu = bus.op_alu; l_sel = bus.intr_sel;
    act = {l_push, l_pop, l_sintr, l_smux, l_sinc, l_malu, l_mdat, l_oe, l_we3, l_wez, l_opalu, l_sel};
    check("ctl", 32'(act), 32'(e_ctl));
    check("ie", 32'(bus.ie), 32'(m_ie));
    check("in_service", 32'(bus.in_service), 32'(m_insvc));
    check("stk_err", 32'(bus.stk_err), 32'(m_err));
    @(posedge clk);
    model_step(op, ir);
    #1;
  endtask

  task automatic do_reset();
    bit [21:0] act;
    reset = 1'b0;
    bus.opcode = 6'b001010; bus.z = 1'b1;
    #1;
    act = {bus.push, bus.pop, bus.s_intr, bus.s_stack_mux, bus.s_inc, bus.s_mux_alu, bus.s_mux_datos,
           bus.transceiver_oe, bus.we3, bus.wez, bus.op_alu, bus.intr_sel};
    check("rst_ctl", 32'(act), 32'h0001_0000);
    check("rst_ie", 32'(bus.ie), 32'd0);
    check("rst_in_service", 32'(bus.in_service), 32'd0);
    check("rst_stk_err", 32'(bus.stk_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  function automatic bit [5:0] rand_op();
    bit [5:0] pool[12] = '{OP_CALL, OP_RET, OP_RETI, OP_EI, OP_EI, OP_DI, OP_J, OP_JZ,
                           OP_JNZ, OP_LOAD, OP_STORE, NOP};
    if ($urandom_range(1, 0) == 0) return 6'($urandom);
    return pool[$urandom_range(11, 0)];
  endfunction

  initial begin
    int gk;
    bit [NI-1:0] ir;
    reset = 1'b0; bus.opcode = '0; bus.z = 1'b0; bus.intr = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Test 1: reset mid-run, then an ALU-immediate instruction
    for (int i = 0; i < 20; i++) cycle(rand_op(), 1'($urandom), '0);
    do_reset();
    cycle(6'b001010, 1'b0, '0);
    check("t1_op_alu", 32'(l_opalu), 32'd2);
    check("t1_mux_alu", 32'(l_malu), 32'd1);
    check("t1_we3_wez", 32'({l_we3, l_wez}), 32'd3);

    // Test 2: conditional jumps
    cycle(OP_JZ, 1'b1, '0);  check("t2_jz_z1", 32'(l_sinc), 32'd0);
    cycle(OP_JZ, 1'b0, '0);  check("t2_jz_z0", 32'(l_sinc), 32'd1);
    cycle(OP_JNZ, 1'b1, '0); check("t2_jnz_z1", 32'(l_sinc), 32'd1);
    cycle(OP_JNZ, 1'b0, '0); check("t2_jnz_z0", 32'(l_sinc), 32'd0);

    // Test 3: simultaneous edges on lines 5 and 2
    repeat (3) cycle(NOP, 1'b0, '0);
    cycle(OP_EI, 1'b0, '0);
    gk = -1;
    for (int k = 0; k < 8 && gk < 0; k++) begin
      cycle(NOP, 1'b0, 8'h24);
      if (l_sel != '0) gk = k;
    end
    check("t3_latency", 32'(gk), 32'(SS + 1));
    check("t3_sel", 32'(l_sel), 32'h04);
    check("t3_push_sintr", 32'({l_push, l_sintr}), 32'd3);
    check("t3_s_inc", 32'(l_sinc), 32'd2);
    cycle(OP_RETI, 1'b0, 8'h24);
    check("t3_reti_sel", 32'(l_sel), 32'h00);
    cycle(NOP, 1'b0, 8'h24);
    check("t3_second_sel", 32'(l_sel), 32'h20);
    cycle(OP_RETI, 1'b0, 8'h24);

    // Test 4: request while disabled is held until EI
    cycle(OP_DI, 1'b0, '0);
    repeat (3) cycle(NOP, 1'b0, '0);
    repeat (5) cycle(NOP, 1'b0, 8'h01);
    check("t4_no_grant", 32'(l_sel), 32'h00);
    cycle(OP_EI, 1'b0, 8'h01);
    check("t4_ei_no_grant", 32'(l_sel), 32'h00);
    cycle(NOP, 1'b0, 8'h01);
    check("t4_grant", 32'(l_sel), 32'h01);
    cycle(OP_RETI, 1'b0, 8'h01);
    cycle(OP_DI, 1'b0, '0);

    // Test 5: stack overflow and underflow
    for (int i = 0; i < SD; i++) begin
      cycle(OP_CALL, 1'b0, '0);
      check("t5_push", 32'(l_push), 32'd1);
    end
    cycle(OP_CALL, 1'b0, '0);
    check("t5_ovf_push", 32'(l_push), 32'd0);
    check("t5_ovf_jump", 32'(l_sinc), 32'd0);
    check("t5_ovf_err", 32'(bus.stk_err), 32'd1);
    for (int i = 0; i < SD; i++) begin
      cycle(OP_RET, 1'b0, '0);
      check("t5_pop", 32'(l_pop), 32'd1);
    end
    cycle(OP_RET, 1'b0, '0);
    check("t5_unf_pop", 32'({l_pop, l_smux}), 32'd0);
    check("t5_unf_sinc", 32'(l_sinc), 32'd1);

    // Test 6: full stack blocks interrupt entry
    for (int i = 0; i < SD; i++) cycle(OP_CALL, 1'b0, '0);
    repeat (3) cycle(NOP, 1'b0, '0);
    cycle(OP_EI, 1'b0, 8'h80);
    repeat (5) cycle(NOP, 1'b0, 8'h80);
    check("t6_full_no_grant", 32'(l_sel), 32'h00);
    cycle(OP_RET, 1'b0, 8'h80);
    check("t6_ret_no_grant", 32'(l_sel), 32'h00);
    cycle(NOP, 1'b0, 8'h80);
    check("t6_grant", 32'(l_sel), 32'h80);
    cycle(OP_RETI, 1'b0, 8'h80);

    // Random phase against the model
    do_reset();
    ir = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) ir ^= NI'(1) << $urandom_range(NI - 1, 0);
      if ($urandom_range(499, 0) == 0) do_reset();
      else cycle(rand_op(), 1'($urandom), ir);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
